// File: rtl/hr_multicycle_ctrl.sv
// rtl/hr_multicycle_ctrl.sv - multi-cycle fetch/decode/execute/memory/writeback sequencer
module hr_multicycle_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [63:0] next_pc_i,
  output logic [63:0] pc_o,
  output logic [31:0] ir_o,
  output logic        alu_we_o,
  output logic        mdr_we_o,
  output logic        reg_we_o,
  output logic        retire_o,
  output logic [31:0] instret_o,
  output logic        trap_o
);

  typedef enum logic [2:0] {
    FETCH_REQ, FETCH_WAIT, DECODE, EXECUTE, MEM_REQ, MEM_WAIT, WRITEBACK, TRAP
  } state_t;

  typedef enum logic [1:0] {
    CLS_R, CLS_LOAD, CLS_STORE, CLS_BRANCH
  } cls_t;

  state_t      state_q, state_d;
  cls_t        cls_q, cls_d;
  logic [63:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] instret_q;
  // Holds off the first fetch request until the first clock after reset release.
  logic        run_q;

  logic        ir_load;
  logic        retire_point;
  logic        retire;
  logic        imem_req;
  logic        dmem_req;
  logic        dmem_we;
  logic        alu_we;
  logic        mdr_we;
  logic        reg_we;
  logic        trap;

  // Next-state and strobe decode; a misaligned target at a retire point diverts to TRAP.
  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    ir_load      = 1'b0;
    retire_point = 1'b0;
    retire       = 1'b0;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    alu_we       = 1'b0;
    mdr_we       = 1'b0;
    reg_we       = 1'b0;
    trap         = 1'b0;

    case (state_q)
      FETCH_REQ: begin
        imem_req = run_q;
        if (run_q && imem_gnt_i) state_d = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (imem_rvalid_i) begin
          ir_load = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = EXECUTE;
        case (ir_q[6:0])
          7'b0110011: cls_d = CLS_R;
          7'b0000011: cls_d = CLS_LOAD;
          7'b0100011: cls_d = CLS_STORE;
          7'b1100011: cls_d = CLS_BRANCH;
          default:    state_d = TRAP;
        endcase
      end
      EXECUTE: begin
        alu_we = 1'b1;
        case (cls_q)
          CLS_BRANCH: begin
            retire_point = 1'b1;
            state_d      = FETCH_REQ;
          end
          CLS_R:   state_d = WRITEBACK;
          default: state_d = MEM_REQ;
        endcase
      end
      MEM_REQ: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CLS_STORE);
        if (dmem_gnt_i) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (dmem_rvalid_i) begin
          if (cls_q == CLS_STORE) begin
            retire_point = 1'b1;
            state_d      = FETCH_REQ;
          end else begin
            mdr_we  = 1'b1;
            state_d = WRITEBACK;
          end
        end
      end
      WRITEBACK: begin
        reg_we       = 1'b1;
        retire_point = 1'b1;
        state_d      = FETCH_REQ;
      end
      default: begin
        trap    = 1'b1;
        state_d = TRAP;
      end
    endcase

    if (retire_point) begin
      if (next_pc_i[1:0] != 2'b00) state_d = TRAP;
      else                         retire  = 1'b1;
    end
  end

  // State, PC, IR and retire counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= FETCH_REQ;
      cls_q     <= CLS_R;
      pc_q      <= RESET_PC;
      ir_q      <= 32'h0;
      instret_q <= 32'h0;
      run_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      run_q   <= 1'b1;
      if (ir_load) ir_q <= imem_rdata_i;
      if (retire) begin
        pc_q      <= next_pc_i;
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  assign imem_req_o = imem_req;
  assign dmem_req_o = dmem_req;
  assign dmem_we_o  = dmem_we;
  assign alu_we_o   = alu_we;
  assign mdr_we_o   = mdr_we;
  assign reg_we_o   = reg_we;
  assign retire_o   = retire;
  assign trap_o     = trap;
  assign pc_o       = pc_q;
  assign ir_o       = ir_q;
  assign instret_o  = instret_q;

endmodule

// File: tb/tb_hr_multicycle_ctrl.sv
// tb/tb_hr_multicycle_ctrl.sv - directed vector bench for hr_multicycle_ctrl
module tb_hr_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [63:0] next_pc, pc;
  logic [31:0] ir, instret;
  logic        alu_we, mdr_we, reg_we, retire, trap;

  int n_tests = 0;
  int n_fail  = 0;

  hr_multicycle_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_o(imem_req), .imem_gnt_i(imem_gnt), .imem_rvalid_i(imem_rvalid),
    .imem_rdata_i(imem_rdata),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_gnt_i(dmem_gnt),
    .dmem_rvalid_i(dmem_rvalid),
    .next_pc_i(next_pc), .pc_o(pc), .ir_o(ir),
    .alu_we_o(alu_we), .mdr_we_o(mdr_we), .reg_we_o(reg_we),
    .retire_o(retire), .instret_o(instret), .trap_o(trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [63:0] npc;
    int          ddelay;
    int          cyc;
    int          n_alu, n_mdr, n_reg, n_dreq, n_dwe, n_ret;
    logic [63:0] pc;
    logic [31:0] instret;
    logic        trap;
  } vec_t;

  // Zero-wait instruction memory plus data memory whose grant lags by ddelay cycles.
  // Entered and left at posedge+1; stops at the first retire_o or trap_o cycle.
  task automatic run_instr(input logic [31:0] instr, input logic [63:0] npc, input int ddelay,
                           output int cyc, output int n_alu, output int n_mdr, output int n_reg,
                           output int n_dreq, output int n_dwe, output int n_ret);
    logic ipend, dpend, done;
    int   dwait;
    ipend = 0; dpend = 0; done = 0; dwait = 0;
    cyc = 0; n_alu = 0; n_mdr = 0; n_reg = 0; n_dreq = 0; n_dwe = 0; n_ret = 0;
    next_pc = npc;
    for (int k = 0; k < 60 && !done; k++) begin
      imem_rvalid = ipend;
      imem_rdata  = ipend ? instr : 32'hDEAD_BEEF;
      imem_gnt    = imem_req;
      dmem_rvalid = dpend;
      dmem_gnt    = dmem_req && (dwait >= ddelay);
      #1;
      cyc++;
      if (alu_we) n_alu++;
      if (mdr_we) n_mdr++;
      if (reg_we) n_reg++;
      if (dmem_req) n_dreq++;
      if (dmem_req && dmem_we) n_dwe++;
      if (retire) n_ret++;
      if (retire || trap) done = 1;
      ipend = imem_req && imem_gnt;
      dpend = dmem_req && dmem_gnt;
      if (dmem_req && !dmem_gnt) dwait++;
      @(posedge clk); #1;
    end
    idle_inputs();
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL timeout: instr 0x%0h did not retire or trap within 60 cycles", instr);
    end
  endtask

  // Assert reset asynchronously, check the reset state, release, check the first request.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check({tag, " rst pc"}, pc, 64'h0);
    check({tag, " rst ir"}, {32'h0, ir}, 64'h0);
    check({tag, " rst instret"}, {32'h0, instret}, 64'h0);
    check({tag, " rst trap"}, {63'h0, trap}, 64'h0);
    check({tag, " rst reqs"}, {62'h0, imem_req, dmem_req}, 64'h0);
    check({tag, " rst strobes"}, {60'h0, alu_we, mdr_we, reg_we, retire}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check({tag, " first imem_req"}, {63'h0, imem_req}, 64'h1);
  endtask

  vec_t vecs[7];

  initial begin
    int cyc, na, nm, nr, nd, nw, nt;
    rst_n = 1'b0;
    next_pc = 64'h0;
    idle_inputs();

    // Sequence runs back to back from reset, so pc/instret accumulate.
    vecs[0] = '{32'h002081B3, 64'h04, 0,  5, 1, 0, 1, 0, 0, 1, 64'h04, 32'd1, 1'b0}; // R add
    vecs[1] = '{32'h0000A183, 64'h08, 3, 10, 1, 1, 1, 4, 0, 1, 64'h08, 32'd2, 1'b0}; // load, gnt +3
    vecs[2] = '{32'h0030A023, 64'h0C, 0,  6, 1, 0, 0, 1, 1, 1, 64'h0C, 32'd3, 1'b0}; // store
    vecs[3] = '{32'h00000063, 64'h40, 0,  4, 1, 0, 0, 0, 0, 1, 64'h40, 32'd4, 1'b0}; // taken branch
    vecs[4] = '{32'h0000A183, 64'h44, 0,  7, 1, 1, 1, 1, 0, 1, 64'h44, 32'd5, 1'b0}; // load zero-wait
    vecs[5] = '{32'h0030A023, 64'h48, 2,  8, 1, 0, 0, 3, 3, 1, 64'h48, 32'd6, 1'b0}; // store, gnt +2
    vecs[6] = '{32'h00000063, 64'h42, 0,  5, 1, 0, 0, 0, 0, 0, 64'h48, 32'd6, 1'b1}; // misaligned

    @(posedge clk); @(posedge clk); #1;
    do_reset("init");
    check("pc at first fetch", pc, 64'h0);

    for (int i = 0; i < 7; i++) begin
      run_instr(vecs[i].instr, vecs[i].npc, vecs[i].ddelay, cyc, na, nm, nr, nd, nw, nt);
      check($sformatf("v%0d cycles", i), cyc, vecs[i].cyc);
      check($sformatf("v%0d alu_we", i), na, vecs[i].n_alu);
      check($sformatf("v%0d mdr_we", i), nm, vecs[i].n_mdr);
      check($sformatf("v%0d reg_we", i), nr, vecs[i].n_reg);
      check($sformatf("v%0d dmem_req", i), nd, vecs[i].n_dreq);
      check($sformatf("v%0d dmem_we", i), nw, vecs[i].n_dwe);
      check($sformatf("v%0d retire", i), nt, vecs[i].n_ret);
      check($sformatf("v%0d pc", i), pc, vecs[i].pc);
      check($sformatf("v%0d instret", i), {32'h0, instret}, {32'h0, vecs[i].instret});
      check($sformatf("v%0d trap", i), {63'h0, trap}, {63'h0, vecs[i].trap});
    end

    // TRAP is sticky: no requests or strobes while grants/valids are offered.
    begin
      int bad;
      bad = 0;
      imem_gnt = 1'b1; dmem_gnt = 1'b1; imem_rvalid = 1'b1; dmem_rvalid = 1'b1;
      next_pc = 64'h100;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        if (imem_req || dmem_req || alu_we || mdr_we || reg_we || retire || !trap) bad++;
      end
      idle_inputs();
      check("trap sticky bad cycles", bad, 0);
      check("trap pc held", pc, 64'h48);
      check("trap instret held", {32'h0, instret}, 64'd6);
    end

    // Illegal opcode 0x13 traps right after DECODE and stays there.
    do_reset("illegal");
    run_instr(32'h00000013, 64'h04, 0, cyc, na, nm, nr, nd, nw, nt);
    check("illegal cycles", cyc, 4);
    check("illegal alu_we", na, 0);
    check("illegal retire", nt, 0);
    check("illegal ir", {32'h0, ir}, 64'h13);
    begin
      int reqs;
      reqs = 0;
      imem_gnt = 1'b1;
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); #1;
        if (imem_req) reqs++;
      end
      idle_inputs();
      check("illegal no imem_req", reqs, 0);
      check("illegal trap held", {63'h0, trap}, 64'h1);
    end

    // Reset in MEM_WAIT of a store, then a stray dmem_rvalid after release.
    do_reset("midstore");
    next_pc = 64'h04;
    imem_gnt = 1'b1;
    @(posedge clk); #1;
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0030A023;
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    @(posedge clk); #1;
    check("midstore execute alu_we", {63'h0, alu_we}, 64'h1);
    @(posedge clk); #1;
    check("midstore dmem_req/we", {62'h0, dmem_req, dmem_we}, 64'h3);
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    check("midstore req dropped", {63'h0, dmem_req}, 64'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midstore async ir", {32'h0, ir}, 64'h0);
    check("midstore async pc", pc, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_rvalid = 1'b1;
    @(posedge clk); #1;
    check("midstore stray retire", {63'h0, retire}, 64'h0);
    check("midstore stray mdr_we", {63'h0, mdr_we}, 64'h0);
    check("midstore fetch_req", {63'h0, imem_req}, 64'h1);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    check("midstore instret", {32'h0, instret}, 64'h0);
    check("midstore still fetching", {63'h0, imem_req}, 64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
